// File: rtl/program_sequencer_if.sv
// program_sequencer_if: decoder, program-memory and debug signals of the program sequencer.
interface program_sequencer_if #(parameter int PC_W = 8, parameter int CNT_W = 16);
    logic             jmp;
    logic             jmp_nz;
    logic [3:0]       ir_nibble;
    logic             dont_jmp;
    logic             halt_req;
    logic             step_req;
    logic             resume_req;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pm_addr;
    logic [PC_W-1:0]  pc;
    logic             hold;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
    modport master (
        output jmp, jmp_nz, ir_nibble, dont_jmp, halt_req, step_req, resume_req, bp_en, bp_addr,
        input  pm_addr, pc, hold, halted, instr_count
    );
    modport slave (
        input  jmp, jmp_nz, ir_nibble, dont_jmp, halt_req, step_req, resume_req, bp_en, bp_addr,
        output pm_addr, pc, hold, halted, instr_count
    );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: program counter, fetch address and debug run control (halt, step, resume, breakpoint).
module program_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic sync_reset,
    program_sequencer_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT, STEP} state_t;
    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pm_addr;
    logic [CNT_W-1:0] cnt_q;
    logic             bp_skip_q, bp_skip_d, take, bp_hit, hold;
    always_comb begin
        take      = bus.jmp | (bus.jmp_nz & ~bus.dont_jmp);
        bp_hit    = state_q == RUN && bus.bp_en && pc_q == bus.bp_addr && !bp_skip_q;
        hold      = state_q == BOOT || state_q == HALT || bp_hit;
        pm_addr   = hold ? pc_q : take ? {pc_q[PC_W-1:4], bus.ir_nibble} : pc_q + 1'b1;
        state_d   = state_q == BOOT ? RUN :
                    state_q == RUN  ? ((bus.halt_req || bp_hit) ? HALT : RUN) :
                    state_q == HALT ? (bus.resume_req ? RUN : bus.step_req ? STEP : HALT) : HALT;
        // leaving HALT arms the skip so the resumed pc is not re-trapped by its own breakpoint
        bp_skip_d = (state_q == HALT && (bus.resume_req || bus.step_req)) ? 1'b1 :
                    ((state_q == RUN || state_q == STEP) && !hold) ? 1'b0 : bp_skip_q;
    end
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state_q   <= BOOT;
            pc_q      <= '0;
            cnt_q     <= '0;
            bp_skip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pm_addr;
            bp_skip_q <= bp_skip_d;
            if (!hold) cnt_q <= cnt_q + 1'b1;
        end
    end
    assign bus.pm_addr     = pm_addr;
    assign bus.pc          = pc_q;
    assign bus.hold        = hold;
    assign bus.halted      = state_q == HALT;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed scenarios plus randomized run-control traffic against a behavioural model.
module tb_program_sequencer;
    logic clk = 1'b0;
    logic sync_reset;
    int checks = 0;
    int errors = 0;
    program_sequencer_if #(.PC_W(8), .CNT_W(16)) bus();
    program_sequencer #(.PC_W(8), .CNT_W(16)) dut (.clk(clk), .sync_reset(sync_reset), .bus(bus));
    always #5 clk = ~clk;

    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;
    int          m_mode;
    logic [7:0]  m_pc;
    logic [15:0] m_cnt;
    logic        m_skip;

    task automatic m_rst();
        m_mode = M_BOOT; m_pc = 8'h00; m_cnt = 16'h0000; m_skip = 1'b0;
    endtask
    function automatic logic m_bp();
        return m_mode == M_RUN && bus.bp_en && m_pc == bus.bp_addr && !m_skip;
    endfunction
    function automatic logic m_hold();
        return m_mode == M_BOOT || m_mode == M_HALT || m_bp();
    endfunction
    function automatic logic [7:0] m_fetch();
        logic [7:0] tgt;
        tgt = {m_pc[7:4], bus.ir_nibble};
        if (m_hold()) return m_pc;
        return (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) ? tgt : m_pc + 8'd1;
    endfunction

    task automatic tick();
        int nm; logic [7:0] np; logic [15:0] nc; logic ns;
        np = m_fetch();
        nc = m_hold() ? m_cnt : m_cnt + 16'd1;
        ns = m_skip;
        nm = m_mode;
        if (m_mode == M_BOOT) nm = M_RUN;
        else if (m_mode == M_RUN && (bus.halt_req || m_bp())) nm = M_HALT;
        else if (m_mode == M_HALT && bus.resume_req) begin nm = M_RUN; ns = 1'b1; end
        else if (m_mode == M_HALT && bus.step_req) begin nm = M_STEP; ns = 1'b1; end
        else if (m_mode == M_STEP) nm = M_HALT;
        if ((m_mode == M_RUN || m_mode == M_STEP) && !m_hold()) ns = 1'b0;
        @(posedge clk);
        if (sync_reset) m_rst();
        else begin m_mode = nm; m_pc = np; m_cnt = nc; m_skip = ns; end
        #1;
    endtask

    task automatic test_reset();
        bus.jmp = 0; bus.jmp_nz = 0; bus.ir_nibble = 0; bus.dont_jmp = 0;
        bus.halt_req = 0; bus.step_req = 0; bus.resume_req = 0; bus.bp_en = 0; bus.bp_addr = 0;
        sync_reset = 1'b1; m_rst();
        #2;
        checks++; if (bus.pm_addr !== 8'h00) begin errors++; $display("FAIL reset_pm_addr: got %0h expected 0", bus.pm_addr); end
        checks++; if (bus.hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %0b expected 1", bus.hold); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", bus.halted); end
        checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %0h expected 0", bus.pc); end
        checks++; if (bus.instr_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0h expected 0", bus.instr_count); end
        tick();
        sync_reset = 1'b0;
    endtask

    task automatic test_linear();
        logic [7:0] exp_pc [5] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.pc !== exp_pc[i]) begin errors++; $display("FAIL linear_pc[%0d]: got %0h expected %0h", i, bus.pc, exp_pc[i]); end
            if (i < 4) tick();
        end
        checks++; if (bus.instr_count !== 16'd3) begin errors++; $display("FAIL linear_count: got %0d expected 3", bus.instr_count); end
    endtask

    task automatic test_jump();
        for (int i = 0; i < 300 && m_pc != 8'h12; i++) tick();
        bus.jmp = 1; bus.ir_nibble = 4'h5; #1;
        checks++; if (bus.pm_addr !== 8'h15) begin errors++; $display("FAIL jmp_pm_addr: got %0h expected 15", bus.pm_addr); end
        tick(); bus.jmp = 0;
        checks++; if (bus.pc !== 8'h15) begin errors++; $display("FAIL jmp_pc: got %0h expected 15", bus.pc); end
        for (int i = 0; i < 300 && m_pc != 8'hFF; i++) tick();
        #1;
        checks++; if (bus.pm_addr !== 8'h00) begin errors++; $display("FAIL wrap_pm_addr: got %0h expected 0", bus.pm_addr); end
        tick();
        checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %0h expected 0", bus.pc); end
    endtask

    task automatic test_jmp_nz();
        for (int i = 0; i < 300 && m_pc != 8'h20; i++) tick();
        bus.jmp_nz = 1; bus.dont_jmp = 1; bus.ir_nibble = 4'h9; #1;
        checks++; if (bus.pm_addr !== 8'h21) begin errors++; $display("FAIL jnz_suppressed_pm: got %0h expected 21", bus.pm_addr); end
        tick();
        checks++; if (bus.pc !== 8'h21) begin errors++; $display("FAIL jnz_suppressed_pc: got %0h expected 21", bus.pc); end
        bus.jmp_nz = 0; bus.jmp = 1; bus.ir_nibble = 4'h0;
        tick();
        bus.jmp = 0; bus.jmp_nz = 1; bus.dont_jmp = 0; bus.ir_nibble = 4'h9; #1;
        checks++; if (bus.pm_addr !== 8'h29) begin errors++; $display("FAIL jnz_taken_pm: got %0h expected 29", bus.pm_addr); end
        tick();
        bus.jmp_nz = 0;
        checks++; if (bus.pc !== 8'h29) begin errors++; $display("FAIL jnz_taken_pc: got %0h expected 29", bus.pc); end
    endtask

    task automatic test_breakpoint();
        logic [15:0] c0;
        bus.bp_en = 1; bus.bp_addr = 8'h06;
        for (int i = 0; i < 300 && m_pc != 8'h06; i++) tick();
        #1;
        checks++; if (bus.hold !== 1'b1) begin errors++; $display("FAIL bp_hold: got %0b expected 1", bus.hold); end
        checks++; if (bus.pm_addr !== 8'h06) begin errors++; $display("FAIL bp_pm_addr: got %0h expected 06", bus.pm_addr); end
        c0 = m_cnt;
        tick();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL bp_halted: got %0b expected 1", bus.halted); end
        repeat (10) tick();
        checks++; if (bus.instr_count !== c0) begin errors++; $display("FAIL bp_count_frozen: got %0h expected %0h", bus.instr_count, c0); end
        checks++; if (bus.pc !== 8'h06 || bus.halted !== 1'b1) begin errors++; $display("FAIL bp_stay: got pc %0h halted %0b expected 06/1", bus.pc, bus.halted); end
    endtask

    task automatic test_step_resume();
        logic [15:0] c0;
        c0 = m_cnt;
        bus.step_req = 1; tick(); bus.step_req = 0; #1;
        checks++; if (bus.hold !== 1'b0) begin errors++; $display("FAIL step_hold: got %0b expected 0", bus.hold); end
        tick();
        checks++; if (bus.pc !== 8'h07) begin errors++; $display("FAIL step_pc: got %0h expected 07", bus.pc); end
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL step_rehalt: got %0b expected 1", bus.halted); end
        checks++; if (bus.instr_count !== c0 + 16'd1) begin errors++; $display("FAIL step_count: got %0h expected %0h", bus.instr_count, c0 + 16'd1); end
        bus.resume_req = 1; tick(); bus.resume_req = 0;
        tick(); tick();
        checks++; if (bus.pc !== 8'h09 || bus.halted !== 1'b0) begin errors++; $display("FAIL resume_run: got pc %0h halted %0b expected 09/0", bus.pc, bus.halted); end
    endtask

    task automatic test_halt_and_bp();
        logic [15:0] c0;
        bus.bp_addr = 8'h0C;
        for (int i = 0; i < 300 && m_pc != 8'h0C; i++) tick();
        bus.halt_req = 1; #1;
        checks++; if (bus.hold !== 1'b1) begin errors++; $display("FAIL halt_bp_hold: got %0b expected 1", bus.hold); end
        c0 = m_cnt;
        tick(); bus.halt_req = 0;
        checks++; if (bus.halted !== 1'b1 || bus.pc !== 8'h0C) begin errors++; $display("FAIL halt_bp_state: got pc %0h halted %0b expected 0c/1", bus.pc, bus.halted); end
        checks++; if (bus.instr_count !== c0) begin errors++; $display("FAIL halt_bp_count: got %0h expected %0h", bus.instr_count, c0); end
        bus.resume_req = 1; tick(); bus.resume_req = 0; #1;
        checks++; if (bus.hold !== 1'b0 || bus.pm_addr !== 8'h0D) begin errors++; $display("FAIL resume_skip: got hold %0b pm %0h expected 0/0d", bus.hold, bus.pm_addr); end
        tick();
        checks++; if (bus.pc !== 8'h0D || bus.halted !== 1'b0) begin errors++; $display("FAIL resume_skip_pc: got pc %0h halted %0b expected 0d/0", bus.pc, bus.halted); end
    endtask

    task automatic test_halt_req();
        logic [15:0] c0;
        bus.bp_en = 0; c0 = m_cnt;
        bus.halt_req = 1; #1;
        checks++; if (bus.hold !== 1'b0) begin errors++; $display("FAIL halt_req_hold: got %0b expected 0", bus.hold); end
        tick(); bus.halt_req = 0;
        checks++; if (bus.halted !== 1'b1 || bus.pc !== 8'h0E) begin errors++; $display("FAIL halt_req_state: got pc %0h halted %0b expected 0e/1", bus.pc, bus.halted); end
        checks++; if (bus.instr_count !== c0 + 16'd1) begin errors++; $display("FAIL halt_req_count: got %0h expected %0h", bus.instr_count, c0 + 16'd1); end
    endtask

    task automatic test_step_held();
        bus.step_req = 1;
        repeat (6) tick();
        bus.step_req = 0;
        checks++; if (bus.pc !== 8'h11 || bus.halted !== 1'b1) begin errors++; $display("FAIL step_held: got pc %0h halted %0b expected 11/1", bus.pc, bus.halted); end
    endtask

    task automatic test_reset_in_step();
        bus.step_req = 1; tick(); bus.step_req = 0;
        sync_reset = 1'b1; m_rst(); #1;
        checks++; if (bus.pc !== 8'h00 || bus.pm_addr !== 8'h00) begin errors++; $display("FAIL step_reset_pc: got pc %0h pm %0h expected 0/0", bus.pc, bus.pm_addr); end
        checks++; if (bus.hold !== 1'b1 || bus.halted !== 1'b0) begin errors++; $display("FAIL step_reset_ctl: got hold %0b halted %0b expected 1/0", bus.hold, bus.halted); end
        checks++; if (bus.instr_count !== 16'h0) begin errors++; $display("FAIL step_reset_count: got %0h expected 0", bus.instr_count); end
        tick();
        sync_reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            bus.jmp = $urandom_range(3) == 0;
            bus.jmp_nz = $urandom_range(3) == 0;
            bus.dont_jmp = $urandom_range(1) == 0;
            bus.ir_nibble = 4'($urandom);
            bus.halt_req = $urandom_range(15) == 0;
            bus.step_req = $urandom_range(3) == 0;
            bus.resume_req = $urandom_range(7) == 0;
            bus.bp_en = $urandom_range(1) == 0;
            if (i % 64 == 0) bus.bp_addr = 8'($urandom);
            sync_reset = $urandom_range(299) == 0;
            if (sync_reset) m_rst();
            #1;
            checks++; if (bus.hold !== m_hold()) begin errors++; $display("FAIL rnd_hold @%0d: got %0b expected %0b", i, bus.hold, m_hold()); end
            checks++; if (bus.pm_addr !== m_fetch()) begin errors++; $display("FAIL rnd_pm_addr @%0d: got %0h expected %0h", i, bus.pm_addr, m_fetch()); end
            checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc @%0d: got %0h expected %0h", i, bus.pc, m_pc); end
            checks++; if (bus.halted !== (m_mode == M_HALT)) begin errors++; $display("FAIL rnd_halted @%0d: got %0b expected %0b", i, bus.halted, m_mode == M_HALT); end
            checks++; if (bus.instr_count !== m_cnt) begin errors++; $display("FAIL rnd_count @%0d: got %0h expected %0h", i, bus.instr_count, m_cnt); end
            tick();
        end
        sync_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_linear();
        test_jump();
        test_jmp_nz();
        test_breakpoint();
        test_step_resume();
        test_halt_and_bp();
        test_halt_req();
        test_step_held();
        test_reset_in_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Program counter and run-control sequencer for the 8-bit-instruction microprocessor. It computes the program-memory fetch address each cycle from the decoder's `jmp`, `jmp_nz` and `ir_nibble` outputs and the ALU zero flag. It adds debug run control: halt, single-step, resume and one address breakpoint. It drives `hold`, which the top level uses to gate all decoder register enables. It sits between the instruction decoder and program memory, whose synchronous read data feeds the decoder's `next_instr`.

## Interface
- `PC_W`, default 8: program counter and program-memory address width.
- `CNT_W`, default 16: executed-instruction counter width.

- `clk` (in, 1): system clock; all state updates on the rising edge.
- `sync_reset` (in, 1): reset, asynchronous and active-high.
- `jmp` (in, 1): unconditional jump, from the decoder.
- `jmp_nz` (in, 1): conditional jump, from the decoder.
- `ir_nibble` (in, 4): jump target low nibble, from the decoder.
- `dont_jmp` (in, 1): ALU zero flag; 1 suppresses `jmp_nz`.
- `halt_req` (in, 1): debug halt request, level-sampled.
- `step_req` (in, 1): debug single-step request, level-sampled.
- `resume_req` (in, 1): debug resume request, level-sampled.
- `bp_en` (in, 1): breakpoint enable.
- `bp_addr` (in, PC_W): breakpoint address.
- `pm_addr` (out, PC_W): program-memory fetch address; combinational.
- `pc` (out, PC_W): address of the instruction currently in the decoder's IR.
- `hold` (out, 1): 1 means the current IR must not execute and all register enables are gated off; combinational.
- `halted` (out, 1): 1 while the state is HALT.
- `instr_count` (out, CNT_W): count of instructions executed, i.e. cycles with `hold` = 0.

## Operation
- States: BOOT, RUN, HALT, STEP.
- Reset: state = BOOT, `pc` = 0, `instr_count` = 0, `bp_skip` = 0.
- Outputs while in reset: `pm_addr` = 0, `hold` = 1, `halted` = 0.
- Jump target: {`pc[PC_W-1:4]`, `ir_nibble`}.
- `take` = `jmp` | (`jmp_nz` & ~`dont_jmp`).
- `bp_hit` = (state == RUN) & `bp_en` & (`pc` == `bp_addr`) & ~`bp_skip`.
- `hold` = (state == BOOT) | (state == HALT) | `bp_hit`.
- `pm_addr` = `hold` ? `pc` : (`take` ? jump target : `pc` + 1). The increment wraps modulo 2^PC_W.
- Every clock edge: `pc` <= `pm_addr`.
- Every clock edge with `hold` = 0: `instr_count` increments and wraps.
- BOOT: always moves to RUN after one cycle. This primes the IR with pm[0].
- RUN: `halt_req` or `bp_hit` moves to HALT. Otherwise the state stays RUN.
- RUN with `halt_req` and `bp_hit` = 0: the current instruction executes and HALT begins at the next instruction.
- RUN with `bp_hit` = 1: the instruction at `bp_addr` is not executed (`hold` = 1 that cycle).
- HALT: `resume_req` moves to RUN and sets `bp_skip` = 1. Else `step_req` moves to STEP and sets `bp_skip` = 1. Else the state stays HALT. `resume_req` has priority over `step_req`.
- STEP: `hold` = 0 for exactly one cycle, executing one instruction including any jump. The state then returns to HALT.
- STEP ignores `halt_req`, `resume_req` and `step_req`. Holding `step_req` high yields one step every 2 cycles.
- `bp_skip` clears on any cycle in RUN or STEP with `hold` = 0. A resume or step therefore always advances past the breakpoint address.
- Jumps are ignored whenever `hold` = 1.

## Timing
- `pm_addr` and `hold` are combinational from state, `pc`, the decoder outputs and `dont_jmp`. All other outputs are registered.
- Program memory has a 1-cycle read latency. The decoder's IR therefore always holds pm[`pc`].
- Jump penalty is 0 cycles. A taken jump fetches the target on the same edge, and the target instruction executes in the next cycle.
- `halt_req` takes effect one edge after it is sampled high.
- A breakpoint takes effect in the same cycle that `pc` equals `bp_addr`.
- Reset asserted mid-operation forces BOOT and `pc` = 0 immediately. `instr_count` is lost.

## Test plan
- Reset, then free-run on a program with no jumps: `pc` follows 0, 0, 1, 2, 3, … and `instr_count` = 3 when `pc` = 3.
- `jmp` with `ir_nibble` = 4'h5 at `pc` = 8'h12: the next `pc` = 8'h15. From `pc` = 8'hFF with no jump, `pc` wraps to 8'h00.
- `jmp_nz` with `dont_jmp` = 1 at `pc` = 8'h20: next `pc` = 8'h21. With `dont_jmp` = 0: next `pc` = 8'h20 + target nibble.
- `bp_en` = 1 and `bp_addr` = 8'h06 in a linear program: `hold` = 1 while `pc` = 6 and `halted` = 1 on the next edge. `instr_count` stays frozen across 10 halted cycles.
- Halted at `pc` = 6: pulse `step_req` once. `pc` = 7 and the state is HALT again, with `instr_count` advanced by exactly 1. Then pulse `resume_req`: running continues to 8, 9, … with no re-halt at 6.
- Assert `halt_req` and `bp_hit` in the same cycle: HALT is entered, and the instruction at the breakpoint is not executed. Assert reset while in STEP: `pc` = 0, `hold` = 1 and `halted` = 0 immediately.
